// File: rtl/reg_bus_if.sv
// Handshake and register-bus bundle between the packet engine, reg_bus_master
// and the register-file responders.
interface reg_bus_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_count;
  // write-data stream
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  // read-data stream
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  // register bus towards the responders
  logic [15:0] reg_raddr;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic [31:0] reg_rdata;
  // status
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_count,
    input  wr_data, wr_valid, rd_ready, reg_rdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last,
    output reg_raddr, reg_waddr, reg_wdata, reg_wen,
    output busy, done, error
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_count,
    output wr_data, wr_valid, rd_ready, reg_rdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last,
    input  reg_raddr, reg_waddr, reg_wdata, reg_wen,
    input  busy, done, error
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator: executes block write / block read commands against
// the board register files. Read data returns through a small credit-managed
// FIFO so the consumer may stall without any data being dropped.
module reg_bus_master #(
  parameter int RD_LATENCY = 2,  // raddr update edge -> rdata sample edge (1..4)
  parameter int FIFO_DEPTH = 4   // power of 2, >= RD_LATENCY+1
) (
  input  logic       sysclk,
  input  logic       reset,
  reg_bus_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // wide enough to hold outstanding + fifo occupancy without overflow
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t       state_reg;
  logic [15:0]  addr_reg;
  logic [7:0]   count_reg;
  logic [15:0]  raddr_reg;
  logic [15:0]  waddr_reg;
  logic [31:0]  wdata_reg;
  logic         wen_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         error_reg;

  // in-flight reads: one valid bit per cycle of responder latency
  logic [RD_LATENCY-1:0] pipe_valid_reg;
  logic [RD_LATENCY-1:0] pipe_last_reg;

  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         fifo_count_reg;

  logic [CW-1:0] outstanding;
  logic          fifo_nonempty;
  logic          wr_ready_int;
  logic          issue;
  logic          push;
  logic          pop;
  logic          last_pop;

  // count reads still travelling through the responder latency
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + CW'(pipe_valid_reg[i]);
    end
  end

  assign fifo_nonempty = (fifo_count_reg != '0);
  // a read is only issued when a FIFO slot is guaranteed for its data
  assign issue         = (state_reg == READ) && ((outstanding + fifo_count_reg) < DEPTH_C);
  assign push          = pipe_valid_reg[RD_LATENCY-1];
  assign pop           = fifo_nonempty && bus.rd_ready;
  assign last_pop      = pop && fifo_last_reg[rd_ptr_reg];
  // count_reg==0 in WRITE is the closing cycle after the final beat
  assign wr_ready_int  = (state_reg == WRITE) && (count_reg != 8'd0);

  // command sequencer with registered bus strobes and status pulses
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      raddr_reg <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      wen_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      wen_reg   <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_reg  <= bus.cmd_addr;
            count_reg <= bus.cmd_count;
            if (bus.cmd_count == 8'd0) begin
              error_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= bus.cmd_write ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (count_reg == 8'd0) begin
            // final reg_wen is on the bus this cycle; complete next
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.wr_valid) begin
            waddr_reg <= addr_reg;
            wdata_reg <= bus.wr_data;
            wen_reg   <= 1'b1;
            addr_reg  <= addr_reg + 16'd1;
            count_reg <= count_reg - 8'd1;
          end
        end
        READ: begin
          if (issue) begin
            raddr_reg <= addr_reg;
            addr_reg  <= addr_reg + 16'd1;
            count_reg <= count_reg - 8'd1;
            if (count_reg == 8'd1) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // shift issued reads through the responder latency, tagging the final one
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pipe_valid_reg <= '0;
      pipe_last_reg  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_last_reg[i]  <= pipe_last_reg[i-1];
      end
      pipe_valid_reg[0] <= issue;
      pipe_last_reg[0]  <= issue && (count_reg == 8'd1);
    end
  end

  // FIFO pointers, occupancy and last flags; push and pop may coincide
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      fifo_last_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg                <= wr_ptr_reg + PW'(1);
        fifo_last_reg[wr_ptr_reg] <= pipe_last_reg[RD_LATENCY-1];
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        fifo_count_reg <= fifo_count_reg + CW'(1);
      end else if (pop && !push) begin
        fifo_count_reg <= fifo_count_reg - CW'(1);
      end
    end
  end

  // FIFO storage; the head is read combinationally so rd_data is valid with rd_valid
  always_ff @(posedge sysclk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= bus.reg_rdata;
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.wr_ready  = wr_ready_int;
  assign bus.rd_data   = fifo_data[rd_ptr_reg];
  assign bus.rd_valid  = fifo_nonempty;
  assign bus.rd_last   = fifo_nonempty && fifo_last_reg[rd_ptr_reg];
  assign bus.reg_raddr = raddr_reg;
  assign bus.reg_waddr = waddr_reg;
  assign bus.reg_wdata = wdata_reg;
  assign bus.reg_wen   = wen_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.error     = error_reg;

endmodule
